// File: rtl/i2c_slave_addr_detect.sv
// I2C slave address-phase detector: conditions raw SCL/SDA, tracks START/STOP,
// shifts in the address and R/W bit, ACKs a match and pulses addr_hit.
// Optional macro I2C_SLV_GEN_CALL_EN also ACKs the general-call write (address 0, bus R/W=0).
module i2c_slave_addr_detect #(
  parameter int              ALEN       = 7,
  parameter logic [ALEN-1:0] SLAVE_ADDR = 7'h50,
  parameter int              MODULE_ID  = 0
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            scl_in,
  input  logic            sda_in,
  output logic            sda_oe,
  output logic            start_det,
  output logic            stop_det,
  output logic            bus_busy,
  output logic [ALEN-1:0] rx_addr,
  output logic            addr_rw,
  output logic            addr_hit,
  output logic [3:0]      mid
);

  typedef enum logic [2:0] {SIDLE, SADDR, SCMP, SACK_ARM, SACK, SHOLD, SIGNORE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ALEN + 1);

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [ALEN:0]   shreg_q, shreg_d;
  logic            scl_s1_q, scl_s1_d, scl_s_q, scl_s_d, scl_dly_q, scl_dly_d;
  logic            sda_s1_q, sda_s1_d, sda_s_q, sda_s_d, sda_dly_q, sda_dly_d;
  logic            sda_oe_q, sda_oe_d;
  logic            start_det_q, start_det_d;
  logic            stop_det_q, stop_det_d;
  logic            bus_busy_q, bus_busy_d;
  logic [ALEN-1:0] rx_addr_q, rx_addr_d;
  logic            addr_rw_q, addr_rw_d;
  logic            addr_hit_q, addr_hit_d;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond, addr_match;

  assign scl_rise   = scl_s_q & ~scl_dly_q;
  assign scl_fall   = ~scl_s_q & scl_dly_q;
  assign sda_rise   = sda_s_q & ~sda_dly_q;
  assign sda_fall   = ~sda_s_q & sda_dly_q;
  assign start_cond = sda_fall & scl_s_q;
  assign stop_cond  = sda_rise & scl_s_q;

`ifdef I2C_SLV_GEN_CALL_EN
  assign addr_match = (shreg_q[ALEN:1] == SLAVE_ADDR) ||
                      ((shreg_q[ALEN:1] == '0) && !shreg_q[0]);
`else
  assign addr_match = (shreg_q[ALEN:1] == SLAVE_ADDR);
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    scl_s1_d    = scl_in;
    scl_s_d     = scl_s1_q;
    scl_dly_d   = scl_s_q;
    sda_s1_d    = sda_in;
    sda_s_d     = sda_s1_q;
    sda_dly_d   = sda_s_q;
    sda_oe_d    = sda_oe_q;
    start_det_d = start_cond;
    stop_det_d  = stop_cond;
    bus_busy_d  = bus_busy_q;
    rx_addr_d   = rx_addr_q;
    addr_rw_d   = addr_rw_q;
    addr_hit_d  = 1'b0;

    if (stop_cond) begin
      state_d    = SIDLE;
      sda_oe_d   = 1'b0;
      bus_busy_d = 1'b0;
    end else if (start_cond) begin
      // START and repeated START both restart the address phase from scratch
      state_d    = SADDR;
      bit_cnt_d  = '0;
      shreg_d    = '0;
      sda_oe_d   = 1'b0;
      bus_busy_d = 1'b1;
    end else begin
      case (state_q)
        SADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[ALEN-1:0], sda_s_q};
            if (bit_cnt_q < CNT_LAST) bit_cnt_d = bit_cnt_q + 4'd1;
            if ((bit_cnt_q + 4'd1) == CNT_LAST) state_d = SCMP;
          end
        end
        SCMP: begin
          rx_addr_d = shreg_q[ALEN:1];
          addr_rw_d = ~shreg_q[0];
          state_d   = addr_match ? SACK_ARM : SIGNORE;
        end
        SACK_ARM: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
            state_d  = SACK;
          end
        end
        SACK: begin
          // release after the ACK clock's falling edge, then hand off
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            addr_hit_d = 1'b1;
            state_d    = SHOLD;
          end
        end
        SIDLE, SHOLD, SIGNORE: ;
        default: state_d = SIDLE;
      endcase
    end

    if (!enable) begin
      state_d     = SIDLE;
      bit_cnt_d   = '0;
      shreg_d     = '0;
      scl_s1_d    = 1'b1;
      scl_s_d     = 1'b1;
      scl_dly_d   = 1'b1;
      sda_s1_d    = 1'b1;
      sda_s_d     = 1'b1;
      sda_dly_d   = 1'b1;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      bus_busy_d  = 1'b0;
      addr_hit_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= SIDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      scl_s1_q    <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_dly_q   <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_dly_q   <= 1'b1;
      sda_oe_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      bus_busy_q  <= 1'b0;
      rx_addr_q   <= '0;
      addr_rw_q   <= 1'b0;
      addr_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      scl_s1_q    <= scl_s1_d;
      scl_s_q     <= scl_s_d;
      scl_dly_q   <= scl_dly_d;
      sda_s1_q    <= sda_s1_d;
      sda_s_q     <= sda_s_d;
      sda_dly_q   <= sda_dly_d;
      sda_oe_q    <= sda_oe_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      bus_busy_q  <= bus_busy_d;
      rx_addr_q   <= rx_addr_d;
      addr_rw_q   <= addr_rw_d;
      addr_hit_q  <= addr_hit_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign bus_busy  = bus_busy_q;
  assign rx_addr   = rx_addr_q;
  assign addr_rw   = addr_rw_q;
  assign addr_hit  = addr_hit_q;
  assign mid       = 4'(MODULE_ID);

endmodule

// File: tb/tb_i2c_slave_addr_detect.sv
// Bench for i2c_slave_addr_detect: a bit-banged I2C master drives address phases
// and the slave's responses are compared with a transaction-level model.
module tb_i2c_slave_addr_detect;
  localparam int         H   = 8;
  localparam int         Q   = 4;
  localparam logic [6:0] SLV = 7'h50;

  logic       clock = 1'b0, rst_n = 1'b0, enable = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, start_det, stop_det, bus_busy, addr_rw, addr_hit;
  logic [6:0] rx_addr;
  logic [3:0] mid;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_addr_detect #(.ALEN(7), .SLAVE_ADDR(SLV), .MODULE_ID(0)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
    .rx_addr(rx_addr), .addr_rw(addr_rw), .addr_hit(addr_hit), .mid(mid));

  always #5 clock = ~clock;

  int vectors = 0, errs = 0;
  int start_cnt = 0, stop_cnt = 0, hit_cnt = 0;
  always @(negedge clock) begin
    if (start_det) start_cnt++;
    if (stop_det)  stop_cnt++;
    if (addr_hit)  hit_cnt++;
  end

  // per-transaction observations
  logic [8:0] oe_obs;
  logic       oe_bad, busy_obs, busy_after, oe_after, rw_obs;
  logic [6:0] rx_obs;
  int         hits, starts, stops;
  logic [6:0] exp_rx = '0;
  logic       exp_rw = 1'b0;

  function automatic logic ref_hit(input logic [6:0] a, input logic rw);
`ifdef I2C_SLV_GEN_CALL_EN
    return (a == SLV) || (a == 7'd0 && rw == 1'b0);
`else
    return (a == SLV);
`endif
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic bus_start;
    sda_m = 1'b0; wclk(H); scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_rstart;
    sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b0; wclk(Q); scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b1; wclk(H);
  endtask

  task automatic bus_bit(input logic b, input int idx);
    wclk(Q); sda_m = b; wclk(Q); scl_m = 1'b1; wclk(H/2);
    @(negedge clock) oe_obs[idx] = sda_oe;
    wclk(H/2); scl_m = 1'b0;
  endtask

  task automatic bus_addr(input logic [6:0] a, input logic rw);
    for (int i = 0; i < 7; i++) bus_bit(a[6-i], i);
    bus_bit(rw, 7);
    bus_bit(1'b1, 8);
  endtask

  task automatic run_xfer(input logic [6:0] a, input logic rw);
    int s0, p0, h0;
    s0 = start_cnt; p0 = stop_cnt; h0 = hit_cnt;
    oe_obs = '0;
    bus_start;
    bus_addr(a, rw);
    wclk(2*H);
    @(negedge clock);
    busy_obs = bus_busy; rx_obs = rx_addr; rw_obs = addr_rw;
    hits = hit_cnt - h0;
    oe_bad = |oe_obs[7:0];
    bus_stop;
    @(negedge clock);
    busy_after = bus_busy; oe_after = sda_oe;
    starts = start_cnt - s0; stops = stop_cnt - p0;
  endtask

  task automatic test_reset;
    wclk(4);
    @(negedge clock);
    vectors++;
    if ({sda_oe, start_det, stop_det, bus_busy, addr_rw, addr_hit} !== 6'b0) begin
      errs++; $display("FAIL reset_ctrl got %b want 000000", {sda_oe, start_det, stop_det, bus_busy, addr_rw, addr_hit});
    end
    vectors++;
    if (rx_addr !== 7'h00) begin errs++; $display("FAIL reset_rx got %h want 00", rx_addr); end
    vectors++;
    if (mid !== 4'd0) begin errs++; $display("FAIL mid got %0d want 0", mid); end
    rst_n = 1'b1;
    wclk(4);
  endtask

  task automatic test_write_match;
    run_xfer(SLV, 1'b0);
    vectors++; if (hits !== 1) begin errs++; $display("FAIL wr_hits got %0d want 1", hits); end
    vectors++; if (oe_obs[8] !== 1'b1) begin errs++; $display("FAIL wr_ack got %b want 1", oe_obs[8]); end
    vectors++; if (oe_bad !== 1'b0) begin errs++; $display("FAIL wr_oe_early got %b want 0", oe_obs); end
    vectors++; if (rx_obs !== SLV) begin errs++; $display("FAIL wr_rx got %h want %h", rx_obs, SLV); end
    vectors++; if (rw_obs !== 1'b1) begin errs++; $display("FAIL wr_rw got %b want 1", rw_obs); end
    vectors++; if (busy_obs !== 1'b1) begin errs++; $display("FAIL wr_busy got %b want 1", busy_obs); end
    vectors++; if (busy_after !== 1'b0) begin errs++; $display("FAIL wr_busy_stop got %b want 0", busy_after); end
    vectors++; if (starts !== 1 || stops !== 1) begin errs++; $display("FAIL wr_st_sp got %0d/%0d want 1/1", starts, stops); end
    exp_rx = SLV; exp_rw = 1'b1;
  endtask

  task automatic test_read_match;
    run_xfer(SLV, 1'b1);
    vectors++; if (hits !== 1) begin errs++; $display("FAIL rd_hits got %0d want 1", hits); end
    vectors++; if (oe_obs[8] !== 1'b1) begin errs++; $display("FAIL rd_ack got %b want 1", oe_obs[8]); end
    vectors++; if (rw_obs !== 1'b0) begin errs++; $display("FAIL rd_rw got %b want 0", rw_obs); end
    vectors++; if (rx_obs !== SLV) begin errs++; $display("FAIL rd_rx got %h want %h", rx_obs, SLV); end
    exp_rx = SLV; exp_rw = 1'b0;
  endtask

  task automatic test_mismatch;
    run_xfer(7'h51, 1'b0);
    vectors++; if (hits !== 0) begin errs++; $display("FAIL mm_hits got %0d want 0", hits); end
    vectors++; if (oe_obs !== 9'b0) begin errs++; $display("FAIL mm_oe got %b want 0", oe_obs); end
    vectors++; if (rx_obs !== 7'h51) begin errs++; $display("FAIL mm_rx got %h want 51", rx_obs); end
    vectors++; if (busy_obs !== 1'b1 || busy_after !== 1'b0) begin errs++; $display("FAIL mm_busy got %b%b want 10", busy_obs, busy_after); end
    exp_rx = 7'h51; exp_rw = 1'b1;
  endtask

  task automatic test_gen_call;
    run_xfer(7'h00, 1'b0);
    vectors++; if (hits !== int'(ref_hit(7'h00, 1'b0))) begin errs++; $display("FAIL gc_wr_hits got %0d want %0d", hits, ref_hit(7'h00, 1'b0)); end
    vectors++; if (oe_obs[8] !== ref_hit(7'h00, 1'b0)) begin errs++; $display("FAIL gc_wr_ack got %b want %b", oe_obs[8], ref_hit(7'h00, 1'b0)); end
    vectors++; if (rx_obs !== 7'h00) begin errs++; $display("FAIL gc_rx got %h want 00", rx_obs); end
    run_xfer(7'h00, 1'b1);
    vectors++; if (hits !== 0 || oe_obs[8] !== 1'b0) begin errs++; $display("FAIL gc_rd got hits %0d ack %b want 0 0", hits, oe_obs[8]); end
    exp_rx = 7'h00; exp_rw = 1'b0;
  endtask

  task automatic test_rep_start;
    int s0, h0;
    logic [3:0] part;
    s0 = start_cnt; h0 = hit_cnt; oe_obs = '0;
    part = 4'b1010;
    bus_start;
    for (int i = 0; i < 4; i++) bus_bit(part[3-i], i);
    bus_rstart;
    bus_addr(SLV, 1'b0);
    wclk(2*H);
    @(negedge clock);
    vectors++; if (hit_cnt - h0 !== 1) begin errs++; $display("FAIL rs_hits got %0d want 1", hit_cnt - h0); end
    vectors++; if (rx_addr !== SLV) begin errs++; $display("FAIL rs_rx got %h want %h", rx_addr, SLV); end
    bus_stop;
    vectors++; if (start_cnt - s0 !== 2) begin errs++; $display("FAIL rs_starts got %0d want 2", start_cnt - s0); end
    exp_rx = SLV; exp_rw = 1'b1;
  endtask

  task automatic test_enable;
    bus_start;
    for (int i = 0; i < 4; i++) bus_bit(1'b1, i);
    enable = 1'b0;
    wclk(2);
    @(negedge clock);
    vectors++; if (bus_busy !== 1'b0 || sda_oe !== 1'b0) begin errs++; $display("FAIL en_ctrl got busy %b oe %b want 0 0", bus_busy, sda_oe); end
    vectors++; if (rx_addr !== exp_rx || addr_rw !== exp_rw) begin errs++; $display("FAIL en_hold got %h/%b want %h/%b", rx_addr, addr_rw, exp_rx, exp_rw); end
    bus_stop;
    enable = 1'b1;
    wclk(4);
  endtask

  task automatic test_stop_mid_reset;
    int h0;
    logic [7:0] ab;
    h0 = hit_cnt;
    bus_start;
    for (int i = 0; i < 3; i++) bus_bit(1'b0, i);
    bus_stop;
    @(negedge clock);
    vectors++; if (hit_cnt - h0 !== 0) begin errs++; $display("FAIL trunc_hits got %0d want 0", hit_cnt - h0); end
    vectors++; if (rx_addr !== exp_rx) begin errs++; $display("FAIL trunc_rx got %h want %h", rx_addr, exp_rx); end
    vectors++; if (bus_busy !== 1'b0) begin errs++; $display("FAIL trunc_busy got %b want 0", bus_busy); end
    ab = {SLV, 1'b0};
    bus_start;
    for (int i = 0; i < 8; i++) bus_bit(ab[7-i], i);
    wclk(Q); sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(H/2);
    @(negedge clock);
    vectors++; if (sda_oe !== 1'b1) begin errs++; $display("FAIL sack_oe got %b want 1", sda_oe); end
    rst_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({sda_oe, start_det, stop_det, bus_busy, addr_rw, addr_hit} !== 6'b0 || rx_addr !== 7'h00) begin
      errs++; $display("FAIL abort_rst got %b rx %h want 000000 rx 00", {sda_oe, start_det, stop_det, bus_busy, addr_rw, addr_hit}, rx_addr);
    end
    rst_n = 1'b1;
    wclk(H/2); scl_m = 1'b0; wclk(H);
    bus_stop;
    @(negedge clock);
    vectors++; if (hit_cnt - h0 !== 0) begin errs++; $display("FAIL abort_hits got %0d want 0", hit_cnt - h0); end
    exp_rx = 7'h00; exp_rw = 1'b0;
  endtask

  task automatic test_random;
    logic [6:0] a;
    logic       rw, exp;
    for (int n = 0; n < 24; n++) begin
      a  = ($urandom_range(2) == 0) ? SLV : 7'($urandom);
      rw = 1'($urandom);
      if (n == 5) a = 7'h00;
      exp = ref_hit(a, rw);
      run_xfer(a, rw);
      vectors++; if (hits !== int'(exp)) begin errs++; $display("FAIL rnd_hits a=%h rw=%b got %0d want %0d", a, rw, hits, exp); end
      vectors++; if (oe_obs[8] !== exp || oe_bad !== 1'b0 || oe_after !== 1'b0) begin errs++; $display("FAIL rnd_oe a=%h got %b want ack %b", a, oe_obs, exp); end
      vectors++; if (rx_obs !== a || rw_obs !== ~rw) begin errs++; $display("FAIL rnd_rx got %h/%b want %h/%b", rx_obs, rw_obs, a, ~rw); end
      vectors++; if (busy_obs !== 1'b1 || busy_after !== 1'b0 || starts !== 1 || stops !== 1) begin
        errs++; $display("FAIL rnd_bus got busy %b%b st %0d sp %0d want 10 1 1", busy_obs, busy_after, starts, stops);
      end
      exp_rx = a; exp_rw = ~rw;
    end
  endtask

  initial begin
    test_reset;
    test_write_match;
    test_read_match;
    test_mismatch;
    test_gen_call;
    test_rep_start;
    test_write_match;
    test_enable;
    test_stop_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/i2c_slave_addr_detect.md
Name: i2c_slave_addr_detect

Overview:
- Bus-side counterpart of the master address-phase controller.
- Monitors raw SCL/SDA, detects START/STOP, and shifts in ALEN address bits plus the R/W bit.
- Compares the received address against SLAVE_ADDR, drives the ACK bit low on a match, and hands the transaction to slave data-phase logic with a one-cycle addr_hit pulse.

Parameters:
- ALEN, 7, address length in bits. Legal range 1..14.
- SLAVE_ADDR, 7'h50, own address, ALEN bits wide, MSB first on the bus.
- MODULE_ID, 0, constant driven on mid output.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  block enable; 0 forces SIDLE and releases SDA.
- scl_in  in  1  raw SCL, asynchronous.
- sda_in  in  1  raw SDA, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain enable).
- start_det  out  1  1-cycle pulse on START or repeated START.
- stop_det  out  1  1-cycle pulse on STOP.
- bus_busy  out  1  1 from START until STOP.
- rx_addr  out  ALEN  last received address, held until next START.
- addr_rw  out  1  WR:1 RD:0. This is the inverse of the bus R/W bit.
- addr_hit  out  1  1-cycle pulse: address matched and ACK completed.
- mid  out  4  MODULE_ID.

Behaviour:

Reset and enable
- Reset values: sda_oe=0, start_det=0, stop_det=0, bus_busy=0, rx_addr=0, addr_rw=0, addr_hit=0. State is SIDLE, bit_cnt=0, synchronizers reset to 1.
- rst_n low in mid-operation aborts immediately with the same values.
- enable=0 behaves like reset, except that rx_addr and addr_rw hold their values.

Input conditioning
- 2-flop synchronizer on each of scl_in and sda_in, plus one delay register each.
- scl_rise / scl_fall / sda_rise / sda_fall come from the synchronized value versus the delayed value.
- Pin-to-detect latency is 3 cycles.
- START = sda_fall while scl_s=1. STOP = sda_rise while scl_s=1.
- start_det and stop_det pulse on the cycle after detection.

State machine
- SIDLE: on START, go to SADDR and clear bit_cnt.
- SADDR: on each scl_rise, shift sda_s into shreg (MSB first) and increment bit_cnt.
  - When bit_cnt reaches ALEN+1, go to SCMP.
- SCMP (1 cycle): rx_addr <= shreg[ALEN:1]; addr_rw <= ~shreg[0].
  - If the address equals SLAVE_ADDR, go to SACK_ARM; otherwise go to SIGNORE.
- SACK_ARM: on scl_fall, sda_oe <= 1 and go to SACK.
- SACK: hold sda_oe through the ACK clock high phase.
  - On the next scl_fall, sda_oe <= 0, addr_hit <= 1 for 1 cycle, and go to SHOLD.
- SHOLD / SIGNORE: wait; sda_oe stays 0.

Global transitions
- START in any state other than SIDLE (repeated START): go to SADDR, clear bit_cnt and shreg, sda_oe <= 0.
- STOP in any state: go to SIDLE, sda_oe <= 0, bus_busy <= 0.
- START and STOP cannot be detected in the same cycle, because they are mutually exclusive on SDA. If stop_det and a START occur on consecutive cycles, both are honoured in order.

Boundary conditions
- bit_cnt is 4 bits and saturates at ALEN+1. It must never wrap.
- STOP arriving during SADDR (truncated address): no addr_hit, rx_addr unchanged.
- SDA changing while SCL is high inside SADDR is START/STOP by definition; there is no sampling glitch path.
- bus_busy is set with start_det and cleared with stop_det.

Optional Feature:
- Macro: I2C_SLV_GEN_CALL_EN.
- Defined: address 0 (all zeros) with bus R/W=0 is also treated as a match and is ACKed.
  - addr_hit pulses and rx_addr=0.
  - General call with bus R/W=1 is ignored (SIGNORE).
- Undefined: only SLAVE_ADDR matches. Address 0 goes to SIGNORE with no ACK.

Test Plan:
- Write match: START, bits 1010000 (0x50), bus R/W=0 → sda_oe=1 for exactly the 9th SCL clock; addr_hit pulses once after the 9th SCL falls; rx_addr=7'h50, addr_rw=1.
- Read match: 0x50 with bus R/W=1 → ACK driven, addr_hit=1, addr_rw=0.
- Mismatch: 0x51 with bus R/W=0 → sda_oe stays 0 throughout, no addr_hit, rx_addr=7'h51, bus_busy=1 until STOP.
- Repeated START after 4 address bits, then a full 0x50 write → bit_cnt restarts, exactly one addr_hit, start_det pulses twice.
- STOP mid-address after 3 bits, then rst_n low during SACK on the next transfer → no addr_hit; sda_oe=0 and all outputs at reset values the cycle after reset.
- General call: 0x00 with bus R/W=0 → ACK plus addr_hit with I2C_SLV_GEN_CALL_EN defined; no ACK without it.
